// File: rtl/hilo_mdu.sv
// HI/LO multiply/divide unit: single-cycle-latency multiply, radix-2
// restoring divide, MTHI/MTLO pass-through onto the HI/LO bypass bus.
module hilo_mdu #(
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        start,
    input  logic [5:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        stall_req,
    output logic [65:0] hilo_bus
);

    typedef enum logic [1:0] {IDLE, MUL, DIV_BUSY, DONE} state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [63:0] prod;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [31:0] dvsr;
    logic        q_neg;
    logic        r_neg;
    logic        dz;

    logic        op_ok;
    logic        launch;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [31:0] quot_s;
    logic [31:0] rem_s;

    assign op_ok  = (op != 6'd0) && ((op & (op - 6'd1)) == 6'd0);
    assign launch = resetn && !flush && start && (state == IDLE) && op_ok;

    // Sign-extending for MULT lets one 64-bit multiplier serve both forms.
    assign ext_a = {{32{op[0] & src_a[31]}}, src_a};
    assign ext_b = {{32{op[0] & src_b[31]}}, src_b};

    assign a_abs = (op[2] && src_a[31]) ? -src_a : src_a;
    assign b_abs = (op[2] && src_b[31]) ? -src_b : src_b;

    assign shifted = {rem, quot[31]};
    assign diff    = shifted - {1'b0, dvsr};

    assign quot_s = dz ? 32'hFFFF_FFFF : (q_neg ? -quot : quot);
    assign rem_s  = r_neg ? -rem : rem;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= 6'd0;
            prod  <= 64'd0;
            quot  <= 32'd0;
            rem   <= 32'd0;
            dvsr  <= 32'd0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            dz    <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= 6'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        unique case (1'b1)
                            op[0], op[1]: begin
                                prod  <= ext_a * ext_b;
                                state <= MUL;
                            end
                            op[2], op[3]: begin
                                quot  <= a_abs;
                                rem   <= 32'd0;
                                dvsr  <= b_abs;
                                q_neg <= op[2] & (src_a[31] ^ src_b[31]);
                                r_neg <= op[2] & src_a[31];
                                dz    <= (src_b == 32'd0);
                                cnt   <= 6'd0;
                                state <= DIV_BUSY;
                            end
                            default: ;
                        endcase
                    end
                end
                MUL: state <= IDLE;
                DIV_BUSY: begin
                    if (!diff[32]) begin
                        rem  <= diff[31:0];
                        quot <= {quot[30:0], 1'b1};
                    end else begin
                        rem  <= shifted[31:0];
                        quot <= {quot[30:0], 1'b0};
                    end
                    if (cnt == 6'(DIV_ITER - 1)) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        stall_req = 1'b0;
        hilo_bus  = 66'd0;
        if (resetn && !flush) begin
            case (state)
                IDLE: begin
                    if (start && op_ok) begin
                        unique case (1'b1)
                            op[5]: hilo_bus = {2'b10, src_a, 32'd0};
                            op[4]: hilo_bus = {2'b01, 32'd0, src_a};
                            default: stall_req = 1'b1;
                        endcase
                    end
                end
                MUL:      hilo_bus  = {2'b11, prod};
                DIV_BUSY: stall_req = 1'b1;
                DONE:     hilo_bus  = {2'b11, rem_s, quot_s};
                default: ;
            endcase
        end
    end

endmodule

// File: doc/hilo_mdu.md
Name: hilo_mdu

Overview:
- Multiply/divide unit in the EX stage. It is the producer side of the HI/LO interface: it generates HI/LO write requests and the 66-bit HI/LO bypass bus {hi_we, lo_we, hi, lo} consumed by the register file's HI/LO forwarding and write ports.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Requests pipeline stalls while a multi-cycle operation is in flight.

Parameters:
- DIV_ITER, 32, radix-2 divider iteration count. Fixed at 32 for 32-bit operands.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- flush  in  1  pipeline flush (exception/branch kill); aborts any in-flight operation.
- start  in  1  EX holds a valid HI/LO-producing instruction this cycle.
- op  in  6  one-hot {mthi, mtlo, divu, div, multu, mult}.
- src_a  in  32  rs operand (dividend / multiplicand / MTHI-MTLO data).
- src_b  in  32  rt operand (divisor / multiplier).
- stall_req  out  1  hold IF/ID/EX this cycle.
- hilo_bus  out  66  {hi_we[65], lo_we[64], hi[63:32], lo[31:0]}. Same format as the EX/MEM/WB HI/LO bypass buses.

Behaviour:
- States: IDLE, MUL, DIV_BUSY, DONE. The iteration counter is 6 bits wide. Quotient, remainder and divisor are held in registers, along with the result sign flags.
- Reset (resetn=0, async): state=IDLE, counter=0, all datapath registers=0. Outputs: stall_req=0, hilo_bus=66'b0.
- hilo_bus=0 in every cycle not listed below. stall_req is combinational from state/start/op.
- op with 0 bits or more than 1 bit set while start=1: no action, no stall, bus=0.
- MTHI (IDLE, start): hilo_bus={1,0,src_a,32'b0} in the same cycle. No stall, no state change.
- MTLO (IDLE, start): hilo_bus={0,1,32'b0,src_a} in the same cycle. No stall, no state change.
- MULT/MULTU (IDLE, start, cycle T0):
  - stall_req=1 in T0.
  - The 64-bit product is registered at the end of T0. MULT is signed x signed; MULTU is unsigned.
  - State goes to MUL.
  - In T1: hilo_bus={1,1,prod[63:32],prod[31:0]}, stall_req=0. State returns to IDLE.
- DIV/DIVU (IDLE, start, cycle T0):
  - stall_req=1 in T0.
  - At the end of T0, latch |src_a|, |src_b| (absolute values for DIV only), the quotient sign (a[31]^b[31]) and the remainder sign (a[31]). Set counter=0 and go to DIV_BUSY.
  - DIV_BUSY: one restoring shift-subtract step per cycle. stall_req=1. After the 32nd step (counter==31) go to DONE. DIV_BUSY therefore spans T1..T32.
  - DONE (T33): apply signs. Drive hilo_bus={1,1,remainder,quotient} with stall_req=0. Next state is IDLE.
  - Total stall is 33 cycles (T0..T32). The result is visible in T33.
- Divide by zero (DIVU and DIV): quotient=32'hFFFFFFFF, remainder=dividend (the original src_a, unsigned/signed as given). Timing is still 33+1 cycles. No exception.
- DIV overflow (0x80000000 / -1): quotient=0x80000000, remainder=0 (natural two's-complement wrap).
- start in MUL, DIV_BUSY or DONE is ignored. EX holds the same instruction during the stall, and the operation must not relaunch.
- flush (any state, synchronous):
  - Next state is IDLE and all in-flight results are discarded.
  - In the flush cycle: hilo_bus=0 and stall_req=0, overriding DONE/MUL output and the MTHI/MTLO pass-through.
  - start in the flush cycle is ignored.
- resetn asserted mid-operation: immediate return to IDLE with all outputs 0. No partial write is ever emitted.
- Only one operation is in flight at a time. Back-to-back: a new start is accepted in the cycle after DONE or MUL.

Test Plan:
- MULT src_a=0xFFFFFFFD (-3), src_b=5 -> T0 stall_req=1; T1 hilo_bus={1,1,0xFFFFFFFF,0xFFFFFFF1}, stall_req=0; T2 bus=0.
- MULTU src_a=0xFFFFFFFF, src_b=2 -> T1 hi=0x00000001, lo=0xFFFFFFFE, both we=1.
- DIV src_a=0xFFFFFFF9 (-7), src_b=2 -> stall_req=1 for exactly 33 cycles; T33 hi=0xFFFFFFFF (-1), lo=0xFFFFFFFD (-3); T34 bus=0.
- DIVU src_a=100, src_b=0 -> T33 lo=0xFFFFFFFF, hi=0x00000064.
- MTHI src_a=0x12345678 -> same cycle bus={1,0,0x12345678,0}, no stall. MTLO immediately after -> {0,1,0,data}.
- DIV started, flush at T10 -> T10 stall_req=0, bus=0; T11..T40 bus stays 0, state IDLE. Repeat with resetn pulsed low at T20 -> outputs 0 immediately; a new DIVU afterwards completes correctly.
